// File: rtl/vga_sync_porch_if.sv
// vga_sync_porch_if: groups the upstream flag/colour inputs and the VGA pin outputs.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the pixel stream is free-running.
interface vga_sync_porch_if #(
    parameter int VIDEO_WIDTH = 3
);
    // Upstream side: active-region flags and colour sampled with them
    logic                   Hsync_i;
    logic                   Vsync_i;
    logic [VIDEO_WIDTH-1:0] red_i;
    logic [VIDEO_WIDTH-1:0] green_i;
    logic [VIDEO_WIDTH-1:0] blue_i;

    // Connector side: active-low syncs, aligned colour, lock status
    logic                   Hsync_o;
    logic                   Vsync_o;
    logic [VIDEO_WIDTH-1:0] red_o;
    logic [VIDEO_WIDTH-1:0] green_o;
    logic [VIDEO_WIDTH-1:0] blue_o;
    logic                   locked_o;

    // Source of the pixel stream, consumer of the VGA outputs
    modport master (
        output Hsync_i, Vsync_i, red_i, green_i, blue_i,
        input  Hsync_o, Vsync_o, red_o, green_o, blue_o, locked_o
    );

    // The porch/sync regenerator itself
    modport slave (
        input  Hsync_i, Vsync_i, red_i, green_i, blue_i,
        output Hsync_o, Vsync_o, red_o, green_o, blue_o, locked_o
    );
endinterface

// File: rtl/vga_sync_porch.sv
// vga_sync_porch: re-derives column/row from the upstream frame start and drives active-low Hsync/Vsync with porches.
// Latency: 2 clk_i cycles from Hsync_i/Vsync_i/colour to Hsync_o/Vsync_o/colour and locked_o.
// Backpressure: none; one pixel is consumed and produced every cycle.
// Option: define VGA_PORCH_BLANK_EN to force black colour outside the active region and whenever the delayed flags are low.
module vga_sync_porch #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 18,
    parameter int H_BACK_PORCH  = 50,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_BACK_PORCH  = 33,
    parameter int VIDEO_WIDTH   = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    vga_sync_porch_if.slave vif
);

    // Counter wrap points and sync windows, all in 10-bit unsigned space
    localparam logic [9:0] COL_LAST     = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST     = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] H_SYNC_LAST  = 10'(TOTAL_COLS - H_BACK_PORCH - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] V_SYNC_LAST  = 10'(TOTAL_ROWS - V_BACK_PORCH - 1);
`ifdef VGA_PORCH_BLANK_EN
    localparam logic [9:0] ACT_COLS     = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS     = 10'(ACTIVE_ROWS);
`endif

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t state_q;
    logic   locked_q;

    // Frame-start detection and column/row counters
    logic       vsync_dly_q, vsync_dly_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic [9:0] col_run, row_run;
    logic       col_wrap;
    logic       frame_start;
    logic       phase_ok;

    // Sync outputs
    logic       in_hsync, in_vsync;
    logic       locked;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    // Colour pipeline: stage 1 holds the raw pixel, stage 2 is the output register
    logic [VIDEO_WIDTH-1:0] red_s1_q,   red_s1_d;
    logic [VIDEO_WIDTH-1:0] green_s1_q, green_s1_d;
    logic [VIDEO_WIDTH-1:0] blue_s1_q,  blue_s1_d;
    logic [VIDEO_WIDTH-1:0] red_q,      red_d;
    logic [VIDEO_WIDTH-1:0] green_q,    green_d;
    logic [VIDEO_WIDTH-1:0] blue_q,     blue_d;
    logic                   pix_pass;

`ifdef VGA_PORCH_BLANK_EN
    // Upstream flags travel alongside the pixel so blanking matches the pixel's own flags
    logic hflag_s1_q, hflag_s1_d;
    logic vflag_s1_q, vflag_s1_d;
`else
    // Hsync_i only qualifies blanking, which this build does not perform
    logic unused_hsync;
    assign unused_hsync = vif.Hsync_i;
`endif

    // Free-run next position, frame-start reload, and whether the reload agrees with free-run
    always_comb begin
        vsync_dly_d = vif.Vsync_i;
        frame_start = vif.Vsync_i && !vsync_dly_q;
        col_wrap    = (col_q == COL_LAST);
        col_run     = col_wrap ? 10'd0 : col_q + 10'd1;
        row_run     = row_q;
        if (col_wrap) begin
            row_run = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
        end
        phase_ok = (col_run == 10'd0) && (row_run == 10'd0);
        col_d    = frame_start ? 10'd0 : col_run;
        row_d    = frame_start ? 10'd0 : row_run;
    end

    // Lock FSM: a frame start locks; a frame start that disagrees with the counters unlocks
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
        end else begin
            locked_q <= (state_q == LOCKED);
            case (state_q)
                UNLOCKED: begin
                    if (frame_start) begin
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_start && !phase_ok) begin
                        state_q <= UNLOCKED;
                    end
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

    // Sync windows are decoded from the counters, which describe the pixel now in stage 1
    always_comb begin
        locked   = (state_q == LOCKED);
        in_hsync = (col_q >= H_SYNC_FIRST) && (col_q <= H_SYNC_LAST);
        in_vsync = (row_q >= V_SYNC_FIRST) && (row_q <= V_SYNC_LAST);
        hsync_d  = !(locked && in_hsync);
        vsync_d  = !(locked && in_vsync);
    end

    // Colour: capture raw pixel, then gate it into the output stage
    always_comb begin
        red_s1_d   = vif.red_i;
        green_s1_d = vif.green_i;
        blue_s1_d  = vif.blue_i;
        pix_pass   = locked;
`ifdef VGA_PORCH_BLANK_EN
        hflag_s1_d = vif.Hsync_i;
        vflag_s1_d = vif.Vsync_i;
        pix_pass   = locked && hflag_s1_q && vflag_s1_q &&
                     (col_q < ACT_COLS) && (row_q < ACT_ROWS);
`endif
        red_d   = pix_pass ? red_s1_q   : '0;
        green_d = pix_pass ? green_s1_q : '0;
        blue_d  = pix_pass ? blue_s1_q  : '0;
    end

    // Counters, edge detector, sync and colour registers; vsync_dly resets high so a
    // reset in the middle of active rows cannot look like a frame start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_dly_q <= 1'b1;
            col_q       <= 10'd0;
            row_q       <= 10'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            red_s1_q    <= '0;
            green_s1_q  <= '0;
            blue_s1_q   <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            vsync_dly_q <= vsync_dly_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            red_s1_q    <= red_s1_d;
            green_s1_q  <= green_s1_d;
            blue_s1_q   <= blue_s1_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

`ifdef VGA_PORCH_BLANK_EN
    // Flags delayed by one stage so they line up with the pixel in stage 1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hflag_s1_q <= 1'b0;
            vflag_s1_q <= 1'b0;
        end else begin
            hflag_s1_q <= hflag_s1_d;
            vflag_s1_q <= vflag_s1_d;
        end
    end
`endif

    assign vif.Hsync_o  = hsync_q;
    assign vif.Vsync_o  = vsync_q;
    assign vif.red_o    = red_q;
    assign vif.green_o  = green_q;
    assign vif.blue_o   = blue_q;
    assign vif.locked_o = locked_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// tb_vga_sync_porch: directed bench for vga_sync_porch with 800-column lines and a short 11-row frame.
// Latency: outputs are expected two edges after the upstream sample that produced them.
// Backpressure: none; one upstream pixel is driven every cycle.
module tb_vga_sync_porch;

    // Horizontal timing at the standard values; vertical shortened to keep the run short.
    // Hsync low at cols 658..749 (640+18 .. 800-50-1); Vsync low at rows 7..8 (6+1 .. 11-2-1).
    localparam int TC = 800;
    localparam int TR = 11;
    localparam int AC = 640;
    localparam int AR = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_porch_if #(.VIDEO_WIDTH(3)) vif ();

    vga_sync_porch #(
        .TOTAL_COLS   (TC),
        .TOTAL_ROWS   (TR),
        .ACTIVE_COLS  (AC),
        .ACTIVE_ROWS  (AR),
        .H_FRONT_PORCH(18),
        .H_BACK_PORCH (50),
        .V_FRONT_PORCH(1),
        .V_BACK_PORCH (2),
        .VIDEO_WIDTH  (3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .vif  (vif)
    );

    int passed = 0;
    int total  = 0;

    // Upstream position about to be driven, and the position the DUT counters hold
    int   uc = 0, ur = 2;
    int   dc = 0, dr = 0;
    logic st = 1'b0;          // expected lock state after the latest edge
    logic vprev = 1'b1;       // expected delayed Vsync_i
    logic shift_pend = 1'b0;  // next frame start arrives out of phase

    // What the DUT sampled at the previous edge; outputs after the current edge show it
    int         p_hc = 0, p_hr = 0;
    logic       p_hf = 1'b0, p_vf = 1'b0, p_lk = 1'b0;
    logic [2:0] p_r = 3'b0, p_g = 3'b0, p_b = 3'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s at up(%0d,%0d) observed=%0h expected=%0h", tag, uc, ur, obs, exp);
        end
    endtask

    // One pixel clock: drive upstream, check outputs after the edge, advance the expectation
    task automatic step(input logic r_in);
        logic       hf, vf, fs, pass;
        logic       e_h, e_v, e_lk;
        logic [2:0] cr, cg, cb, e_r, e_g, e_b;
        hf = (uc < AC);
        vf = (ur < AR);
        cr = 3'(uc ^ ur ^ 5);   // 3'b101 at col 0 row 0
        cg = 3'(uc + 3);
        cb = 3'(ur);
        rst = r_in;
        vif.Hsync_i = hf;
        vif.Vsync_i = vf;
        vif.red_i   = cr;
        vif.green_i = cg;
        vif.blue_i  = cb;
        @(posedge clk);
        #1;
        if (r_in) begin
            e_h = 1'b1; e_v = 1'b1; e_lk = 1'b0; pass = 1'b0;
        end else begin
            e_lk = p_lk;
            e_h  = !(p_lk && p_hc >= 658 && p_hc <= 749);
            e_v  = !(p_lk && p_hr >= 7 && p_hr <= 8);
            pass = p_lk;
`ifdef VGA_PORCH_BLANK_EN
            pass = pass && p_hf && p_vf && (p_hc < 640) && (p_hr < 6);
`endif
        end
        e_r = pass ? p_r : 3'b000;
        e_g = pass ? p_g : 3'b000;
        e_b = pass ? p_b : 3'b000;
        chk("locked_o", vif.locked_o, e_lk);
        chk("Hsync_o",  vif.Hsync_o,  e_h);
        chk("Vsync_o",  vif.Vsync_o,  e_v);
        chk("red_o",    vif.red_o,    e_r);
        chk("green_o",  vif.green_o,  e_g);
        chk("blue_o",   vif.blue_o,   e_b);
        if (r_in) begin
            st = 1'b0; vprev = 1'b1; dc = 0; dr = 0;
        end else begin
            fs    = vf && !vprev;
            vprev = vf;
            if (fs) begin
                st = !shift_pend;
                shift_pend = 1'b0;
                dc = 0; dr = 0;
            end else begin
                dc++;
                if (dc == TC) begin
                    dc = 0; dr++;
                    if (dr == TR) dr = 0;
                end
            end
        end
        p_hc = dc; p_hr = dr; p_hf = hf; p_vf = vf; p_lk = st;
        p_r = cr; p_g = cg; p_b = cb;
        uc++;
        if (uc == TC) begin
            uc = 0; ur++;
            if (ur == TR) ur = 0;
        end
    endtask

    task automatic run_to(input int c, input int r);
        int n;
        n = 0;
        while (!(uc == c && ur == r) && n < 20000) begin
            step(1'b0);
            n++;
        end
    endtask

    initial begin
        int hl, vl, j;
        // Reset with Vsync_i high (row 2), then release: no lock until a genuine rising edge
        repeat (3) step(1'b1);
        run_to(0, 0);
        chk("unlocked_before_edge", vif.locked_o, 1'b0);
        step(1'b0);                           // frame start sampled here
        chk("lock_not_yet", vif.locked_o, 1'b0);
        step(1'b0);                           // pixel (0,0) now at the outputs
        chk("lock_rise", vif.locked_o, 1'b1);
        chk("red_at_00", vif.red_o, 3'b101);
        chk("hs_at_00", vif.Hsync_o, 1'b1);
        chk("vs_at_00", vif.Vsync_o, 1'b1);

        // One full locked frame: 92 low Hsync cycles per line, 2 lines of low Vsync
        hl = 0; vl = 0;
        repeat (TC * TR) begin
            step(1'b0);
            if (vif.Hsync_o === 1'b0) hl++;
            if (vif.Vsync_o === 1'b0) vl++;
        end
        chk("hs_low_cycles", hl, 92 * 11);
        chk("vs_low_cycles", vl, 1600);

        // Upstream jumps 5 columns ahead; the early frame start unlocks, the next relocks
        run_to(100, 1);
        uc = 105;
        shift_pend = 1'b1;
        run_to(0, 0);
        step(1'b0);
        step(1'b0);
        chk("unlock_on_shift", vif.locked_o, 1'b0);
        run_to(0, 0);
        step(1'b0);
        step(1'b0);
        chk("relock_after_shift", vif.locked_o, 1'b1);
        j = 0;
        while (vif.Hsync_o !== 1'b0 && j < TC) begin
            step(1'b0);
            j++;
        end
        chk("hs_edge_col", j, 658);

        // One-cycle reset at col 700 while Hsync_o is low
        run_to(700, 2);
        chk("hs_low_pre_rst", vif.Hsync_o, 1'b0);
        step(1'b1);
        chk("hs_after_rst", vif.Hsync_o, 1'b1);
        chk("lock_after_rst", vif.locked_o, 1'b0);
        run_to(0, 0);
        chk("still_unlocked", vif.locked_o, 1'b0);
        step(1'b0);
        step(1'b0);
        chk("relock_after_rst", vif.locked_o, 1'b1);
        repeat (20) step(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
